// File: rtl/lpc_sniffer_pkg.sv
// Shared LPC sniffer types and constants: capture-buffer read FSM states,
// default RAM geometry and the width of the optional drop counter.
package lpc_sniffer_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;
  localparam int DROPCNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } rd_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/buffer_ctrl.sv
// FIFO controller for the sniffer capture RAM: ring pointers, a three-state read
// sequencer and a valid/ready output port. Define BUFFER_CTRL_DROPCNT_EN for drop_cnt.
module buffer_ctrl
  import lpc_sniffer_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          empty,
  output logic          full,
  output logic          overflow
`ifdef BUFFER_CTRL_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0] drop_cnt
`endif
);

  localparam logic [AW-1:0] OCC_MAX = '1;

  rd_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] occupancy;
  logic          empty_w;
  logic          full_w;
  logic          push;
  logic          drop;
  logic          pop;

  // Flags come from the registered pointers only, so a pop on this edge
  // cannot make room for a push on the same edge.
  always_comb begin
    occupancy = wr_ptr_q - rd_ptr_q;
    empty_w   = (occupancy == '0);
    full_w    = (occupancy == OCC_MAX);
    push      = in_valid && !full_w;
    drop      = in_valid && full_w;
    pop       = (state_q == PRESENT) && out_ready;
  end

  // ---------------------------------------------------------------------------
  // State register (FSM state plus datapath flops)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps these blocks free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty_w)  state_d = FETCH;
      FETCH:                  state_d = PRESENT;
      PRESENT: if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | drop;

    // RAM was addressed with rd_ptr on the IDLE->FETCH edge; its data is ready now.
    if (state_q == FETCH) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata;
    end
    if (pop) out_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      overflow_d  = 1'b0;
    end
  end

`ifdef BUFFER_CTRL_DROPCNT_EN
  logic [DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    if (flush) drop_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The slot at wr_ptr is always free, so writing it every cycle is harmless.
  always_comb begin
    ram_wdata = in_data;
    ram_waddr = wr_ptr_q;
    ram_raddr = rd_ptr_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    empty     = empty_w;
    full      = full_w;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl (AW=4): queue-based reference model,
// behavioural registered-read RAM, one task per scenario.
module tb_buffer_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int MAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          empty;
  logic          full;
  logic          overflow;
`ifdef BUFFER_CTRL_DROPCNT_EN
  logic [15:0]   drop_cnt;
`endif

  buffer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .ram_wdata (ram_wdata),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
`ifdef BUFFER_CTRL_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read, no write enable.
  logic [DW-1:0] mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    mem[ram_waddr] <= ram_wdata;
    ram_rdata      <= mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents = records accepted and not yet handed over.
  logic [DW-1:0] q[$];
  logic [DW-1:0] recv[$];
  bit            ovf_m;
  logic [15:0]   drops_m;
  bit            m_was_full;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  bit            mon_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      q.delete();
      ovf_m     = 1'b0;
      drops_m   = '0;
      prev_hold = 1'b0;
    end else begin
      m_was_full = (q.size() == MAX);
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_data: got %h, model queue is empty", out_data);
        end else begin
          if (out_data !== q[0]) begin
            n_bad++;
            $display("FAIL pop_data: got %h, expected %h", out_data, q[0]);
          end
          recv.push_back(out_data);
          void'(q.pop_front());
        end
      end
      if (in_valid) begin
        if (!m_was_full) q.push_back(in_data);
        else begin
          ovf_m = 1'b1;
          if (drops_m != 16'hFFFF) drops_m = drops_m + 16'd1;
        end
      end
    end
  end

  // Flag and hold checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      n_cmp++;
      if (empty !== (q.size() == 0)) begin
        n_bad++;
        $display("FAIL mon_empty: got %b, expected %b (occ %0d)", empty, q.size() == 0, q.size());
      end
      n_cmp++;
      if (full !== (q.size() == MAX)) begin
        n_bad++;
        $display("FAIL mon_full: got %b, expected %b (occ %0d)", full, q.size() == MAX, q.size());
      end
      n_cmp++;
      if (overflow !== ovf_m) begin
        n_bad++;
        $display("FAIL mon_overflow: got %b, expected %b", overflow, ovf_m);
      end
`ifdef BUFFER_CTRL_DROPCNT_EN
      n_cmp++;
      if (drop_cnt !== drops_m) begin
        n_bad++;
        $display("FAIL mon_drop_cnt: got %h, expected %h", drop_cnt, drops_m);
      end
`endif
      if (prev_hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_bad++;
          $display("FAIL mon_hold: got valid=%b data=%h, expected valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: out_valid=0 after 20 cycles, expected 1", tag);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_out_valid("reset");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_cmp++;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b, expected 1", empty); end
    n_cmp++;
    if (overflow !== 1'b0 || full !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got overflow=%b full=%b, expected 0 0", overflow, full);
    end
    n_cmp++;
    if (ram_waddr !== '0 || ram_raddr !== '0) begin
      n_bad++; $display("FAIL reset_ptrs: got waddr=%0d raddr=%0d, expected 0 0", ram_waddr, ram_raddr);
    end
    n_cmp++;
    if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;          // driven just after edge N, captured at N+1
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (e == 3)) begin
        n_bad++; $display("FAIL single_valid_N+%0d: got %b, expected %b", e, out_valid, e == 3);
      end
      if (e == 3) begin
        n_cmp++;
        if (out_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h, expected a5", out_data); end
      end
      if (e == 4) begin
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty: got %b, expected 1", empty); end
      end
      if (e < 4) step();
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = DW'($urandom);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    step();
    in_valid = 1'b0;
    wait_out_valid("bp");
    for (int i = 0; i < 20; i++) begin
      step();
      in_data = DW'($urandom);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== d) begin
        n_bad++; $display("FAIL bp_hold_%0d: got valid=%b data=%h, expected 1 %h", i, out_valid, out_data, d);
      end
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid=%b, expected 0", out_valid); end
    step();
  endtask

  task automatic test_fill();
    bit done = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL fill_full: got full=%b overflow=%b, expected 1 1", full, overflow);
    end
    recv.delete();
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      done = empty && !out_valid;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!done || recv.size() != MAX) begin
      n_bad++; $display("FAIL fill_drain_count: got %0d records, expected %0d", recv.size(), MAX);
    end
    for (int i = 0; i < recv.size(); i++) begin
      n_cmp++;
      if (recv[i] !== DW'(i)) begin n_bad++; $display("FAIL fill_order_%0d: got %h, expected %h", i, recv[i], DW'(i)); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_out_valid("flush");
    step();
    flush     = 1'b1;   // flush must win over push and pop on the same edge
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_state: got empty=%b valid=%b, expected 1 0", empty, out_valid);
    end
    n_cmp++;
    if (overflow !== 1'b0 || full !== 1'b0) begin
      n_bad++; $display("FAIL flush_flags: got overflow=%b full=%b, expected 0 0", overflow, full);
    end
`ifdef BUFFER_CTRL_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL flush_drop_cnt: got %h, expected 0000", drop_cnt); end
`endif
    step();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    recv.delete();
    for (int c = 0; c < 3000 && recv.size() < 40; c++) begin
      in_valid = (sent.size() < 40) && (q.size() < MAX) && ($urandom_range(0, 1) == 1);
      in_data  = DW'($urandom);
      if (in_valid) sent.push_back(in_data);
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (recv.size() != 40 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL wrap_count: got %0d records overflow=%b, expected 40 0", recv.size(), overflow);
    end
    for (int i = 0; i < recv.size() && i < sent.size(); i++) begin
      n_cmp++;
      if (recv[i] !== sent[i]) begin n_bad++; $display("FAIL wrap_order_%0d: got %h, expected %h", i, recv[i], sent[i]); end
    end
    step();
  endtask

`ifdef BUFFER_CTRL_DROPCNT_EN
  task automatic test_drop_saturate();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < MAX + 65535 + 4; i++) begin
      in_data = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL drop_saturate: got %h, expected ffff", drop_cnt); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL drop_clear: got %h, expected 0000", drop_cnt); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_flush();
    test_wrap();
`ifdef BUFFER_CTRL_DROPCNT_EN
    test_drop_saturate();
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
